// File: rtl/pram_loader_pkg.sv
// Shared types and constants for the program-RAM loader.
package pram_loader_pkg;

    localparam int unsigned BYTES_PER_WORD = 2;
    localparam int unsigned ERR_W          = 2;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LEN_HI,
        ST_LEN_LO,
        ST_DATA_HI,
        ST_DATA_LO,
        ST_WRITE,
        ST_CHK,
        ST_DONE,
        ST_ERR
    } state_t;

    localparam logic [ERR_W-1:0] ERR_NONE = 2'b00;
    localparam logic [ERR_W-1:0] ERR_LEN  = 2'b01;
    localparam logic [ERR_W-1:0] ERR_CHK  = 2'b10;
    localparam logic [ERR_W-1:0] ERR_TMO  = 2'b11;

    // States in which a stalled byte stream counts towards the timeout.
    function automatic logic is_timed(input state_t s);
        return (s == ST_LEN_LO) || (s == ST_DATA_HI) || (s == ST_DATA_LO) || (s == ST_CHK);
    endfunction

endpackage

// File: rtl/pram_loader_timer.sv
// Idle-cycle counter: flags expiry after TIMEOUT_CYC enabled cycles without a clear.
module pram_loader_timer #(
    parameter int unsigned TIMEOUT_CYC = 65535
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    generate
        if (TIMEOUT_CYC == 0) begin : g_off
            assign expired = 1'b0;
        end else begin : g_on
            localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
            localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYC - 1);

            logic [CNT_W-1:0] cnt;

            // Counts idle cycles already elapsed; saturates at LAST.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt <= '0;
                end else if (clr || !en) begin
                    cnt <= '0;
                end else if (cnt != LAST) begin
                    cnt <= cnt + CNT_W'(1);
                end
            end

            assign expired = en && !clr && (cnt == LAST);
        end
    endgenerate

endmodule

// File: rtl/pram_loader.sv
// Byte-stream loader for the program RAM: length, big-endian words, checksum.
module pram_loader
    import pram_loader_pkg::*;
#(
    parameter int unsigned ADDR_W      = 12,
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned TIMEOUT_CYC = 65535
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              pram_cs,
    output logic              pram_we,
    output logic [ADDR_W-1:0] pram_adr,
    output logic [DATA_W-1:0] pram_data,
    output logic              busy,
    output logic              done,
    output logic [ERR_W-1:0]  err
);

    localparam logic [16:0] MAX_WORDS = 17'(2 ** ADDR_W);

    state_t            state;
    logic [7:0]        len_hi;
    logic [7:0]        data_hi;
    logic [7:0]        sum;
    logic [ADDR_W-1:0] idx;
    logic [ADDR_W-1:0] last_idx;

    logic        rx_fire_c;
    logic        timer_en_c;
    logic        tmo_c;
    logic        len_bad_c;
    logic [15:0] len_c;
    logic [7:0]  sum_nxt_c;

    assign rx_fire_c  = rx_valid && rx_ready;
    assign timer_en_c = is_timed(state);
    assign len_c      = {len_hi, rx_data};
    assign len_bad_c  = (len_c == 16'd0) || ({1'b0, len_c} > MAX_WORDS);
    assign sum_nxt_c  = sum + rx_data;

    pram_loader_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (rx_fire_c),
        .en      (timer_en_c),
        .expired (tmo_c)
    );

    // Frame sequencer; every output is a flop updated alongside the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            len_hi    <= '0;
            data_hi   <= '0;
            sum       <= '0;
            idx       <= '0;
            last_idx  <= '0;
            rx_ready  <= 1'b0;
            pram_cs   <= 1'b0;
            pram_we   <= 1'b0;
            pram_adr  <= '0;
            pram_data <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= ERR_NONE;
        end else begin
            pram_cs <= 1'b0;
            pram_we <= 1'b0;
            if (rx_fire_c) begin
                sum <= sum_nxt_c;
            end

            if (tmo_c) begin
                state    <= ST_ERR;
                err      <= ERR_TMO;
                busy     <= 1'b0;
                rx_ready <= 1'b0;
            end else begin
                unique case (state)
                    ST_IDLE, ST_DONE, ST_ERR: begin
                        if (start) begin
                            state    <= ST_LEN_HI;
                            done     <= 1'b0;
                            err      <= ERR_NONE;
                            idx      <= '0;
                            sum      <= '0;
                            busy     <= 1'b1;
                            rx_ready <= 1'b1;
                        end
                    end
                    ST_LEN_HI: begin
                        if (rx_fire_c) begin
                            len_hi <= rx_data;
                            state  <= ST_LEN_LO;
                        end
                    end
                    ST_LEN_LO: begin
                        if (rx_fire_c) begin
                            if (len_bad_c) begin
                                state    <= ST_ERR;
                                err      <= ERR_LEN;
                                busy     <= 1'b0;
                                rx_ready <= 1'b0;
                            end else begin
                                last_idx <= ADDR_W'(len_c - 16'd1);
                                state    <= ST_DATA_HI;
                            end
                        end
                    end
                    ST_DATA_HI: begin
                        if (rx_fire_c) begin
                            data_hi <= rx_data;
                            state   <= ST_DATA_LO;
                        end
                    end
                    ST_DATA_LO: begin
                        if (rx_fire_c) begin
                            pram_data <= DATA_W'({data_hi, rx_data});
                            pram_adr  <= idx;
                            pram_cs   <= 1'b1;
                            pram_we   <= 1'b1;
                            rx_ready  <= 1'b0;
                            state     <= ST_WRITE;
                        end
                    end
                    ST_WRITE: begin
                        rx_ready <= 1'b1;
                        if (idx == last_idx) begin
                            state <= ST_CHK;
                        end else begin
                            idx   <= idx + ADDR_W'(1);
                            state <= ST_DATA_HI;
                        end
                    end
                    ST_CHK: begin
                        if (rx_fire_c) begin
                            busy     <= 1'b0;
                            rx_ready <= 1'b0;
                            if (sum_nxt_c == 8'd0) begin
                                state <= ST_DONE;
                                done  <= 1'b1;
                            end else begin
                                state <= ST_ERR;
                                err   <= ERR_CHK;
                            end
                        end
                    end
                    default: begin
                        state    <= ST_IDLE;
                        busy     <= 1'b0;
                        rx_ready <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pram_loader.sv
// Directed bench for pram_loader: frames, error paths, timeout and mid-frame reset.
module tb_pram_loader;

    localparam int unsigned ADDR_W = 12;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned TMO    = 16;

    logic              clk      = 1'b0;
    logic              rst_n    = 1'b1;
    logic              start    = 1'b0;
    logic [7:0]        rx_data  = 8'h00;
    logic              rx_valid = 1'b0;
    logic              rx_ready;
    logic              pram_cs;
    logic              pram_we;
    logic [ADDR_W-1:0] pram_adr;
    logic [DATA_W-1:0] pram_data;
    logic              busy;
    logic              done;
    logic [1:0]        err;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pram_loader #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .pram_cs   (pram_cs),
        .pram_we   (pram_we),
        .pram_adr  (pram_adr),
        .pram_data (pram_data),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    // RAM-side observer: logs writes as the RAM would capture them.
    logic [ADDR_W-1:0] wr_adr[$];
    logic [DATA_W-1:0] wr_dat[$];
    int   cs_long  = 0;
    int   we_no_cs = 0;
    logic prev_cs  = 1'b0;

    always @(posedge clk) begin
        if (pram_cs && pram_we) begin
            wr_adr.push_back(pram_adr);
            wr_dat.push_back(pram_data);
        end
        if (pram_cs && prev_cs) cs_long++;
        if (pram_we != pram_cs) we_no_cs++;
        prev_cs = pram_cs;
    end

    logic [7:0] frame[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] get_wr(input int i);
        if (i < wr_adr.size()) return 64'({wr_adr[i], wr_dat[i]});
        return '1;
    endfunction

    task automatic clear_log();
        wr_adr.delete();
        wr_dat.delete();
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge just after the byte transfers.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        for (int i = 0; i < gap; i++) begin
            rx_valid = 1'b0;
            @(negedge clk);
        end
        rx_valid = 1'b1;
        rx_data  = b;
        n = 0;
        while (!rx_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!rx_ready) begin
            check("rx_ready_wait", 64'(rx_ready), 64'd1);
        end else begin
            @(negedge clk);
        end
    endtask

    task automatic send_frame(input int max_gap);
        int gap;
        foreach (frame[i]) begin
            gap = 0;
            if (max_gap > 0 && $urandom_range(0, 3) == 0) gap = int'($urandom_range(1, max_gap));
            send_byte(frame[i], gap);
        end
        rx_valid = 1'b0;
    endtask

    initial begin
        logic [7:0] s;

        // Reset
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", 64'({rx_ready, pram_cs, pram_we, pram_adr, pram_data, busy, done, err}), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_after_reset", 64'({busy, rx_ready, done, err}), 64'd0);

        // Nominal two-word frame, back-to-back bytes
        do_start();
        check("nom_busy_ready", 64'({busy, rx_ready}), 64'b11);
        clear_log();
        frame = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};
        send_frame(0);
        check("nom_done_err_busy", 64'({done, err, busy}), 64'b1000);
        check("nom_wr_cnt", 64'(wr_adr.size()), 64'd2);
        check("nom_wr0", get_wr(0), 64'({12'h000, 16'h1234}));
        check("nom_wr1", get_wr(1), 64'({12'h001, 16'hABCD}));

        // Bad checksum
        do_start();
        check("chk_done_cleared", 64'({done, err, busy}), 64'b0001);
        clear_log();
        frame = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h41};
        send_frame(0);
        check("chk_wr_cnt", 64'(wr_adr.size()), 64'd2);
        check("chk_wr1", get_wr(1), 64'({12'h001, 16'hABCD}));
        check("chk_done_err_busy", 64'({done, err, busy}), 64'b0100);

        // Bad length: zero and one past the RAM size
        do_start();
        clear_log();
        frame = '{8'h00, 8'h00};
        send_frame(0);
        check("len0_err", 64'({done, err, busy, rx_ready}), 64'b00100);
        repeat (3) @(negedge clk);
        check("len0_no_write", 64'(wr_adr.size()), 64'd0);
        do_start();
        frame = '{8'h10, 8'h01};
        send_frame(0);
        check("len4097_err", 64'({done, err, busy, rx_ready}), 64'b00100);
        repeat (3) @(negedge clk);
        check("len4097_no_write", 64'(wr_adr.size()), 64'd0);

        // Full 4096-word frame with random rx_valid gaps
        do_start();
        clear_log();
        frame = '{8'h10, 8'h00};
        s = 8'h10;
        for (int i = 0; i < 4096; i++) begin
            frame.push_back(8'(i >> 8));
            frame.push_back(8'(i));
            s = s + 8'(i >> 8) + 8'(i);
        end
        frame.push_back(8'(0) - s);
        send_frame(5);
        check("full_done_err", 64'({done, err, busy}), 64'b1000);
        check("full_wr_cnt", 64'(wr_adr.size()), 64'd4096);
        check("full_last", get_wr(4095), 64'({12'hFFF, 16'h0FFF}));
        begin
            int bad_words = 0;
            for (int i = 0; i < 4096; i++) begin
                if (get_wr(i) !== 64'({12'(i), 16'(i)})) bad_words++;
            end
            check("full_word_errors", 64'(bad_words), 64'd0);
        end
        repeat (10) @(negedge clk);
        check("full_no_extra_write", 64'(wr_adr.size()), 64'd4096);

        // Timeout after three bytes
        do_start();
        clear_log();
        frame = '{8'h00, 8'h03, 8'h12};
        send_frame(0);
        repeat (15) @(negedge clk);
        check("tmo_not_yet", 64'({err, busy}), 64'b001);
        @(negedge clk);
        check("tmo_fired", 64'({err, busy, rx_ready, done}), 64'b11000);
        repeat (5) @(negedge clk);
        check("tmo_ready_low", 64'(rx_ready), 64'd0);
        check("tmo_no_write", 64'(wr_adr.size()), 64'd0);

        // Clean frame after timeout; a start pulse during a byte is ignored
        do_start();
        clear_log();
        frame = '{8'h00, 8'h01};
        send_frame(0);
        start = 1'b1;
        send_byte(8'hBE, 0);
        start = 1'b0;
        frame = '{8'hEF, 8'h52};
        send_frame(0);
        check("post_tmo_done", 64'({done, err, busy}), 64'b1000);
        check("post_tmo_wr_cnt", 64'(wr_adr.size()), 64'd1);
        check("post_tmo_wr0", get_wr(0), 64'({12'h000, 16'hBEEF}));

        // Reset while in DATA_LO
        do_start();
        clear_log();
        frame = '{8'h00, 8'h02, 8'h12};
        send_frame(0);
        check("rst_pre_busy", 64'({busy, rx_ready}), 64'b11);
        #2 rst_n = 1'b0;
        #1 check("rst_async_outputs", 64'({rx_ready, pram_cs, pram_we, pram_adr, pram_data, busy, done, err}), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check("rst_no_write", 64'(wr_adr.size()), 64'd0);
        @(negedge clk);
        check("rst_idle", 64'({busy, rx_ready, done, err}), 64'd0);
        do_start();
        frame = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};
        send_frame(0);
        check("rst_reload_done", 64'({done, err, busy}), 64'b1000);
        check("rst_reload_wr_cnt", 64'(wr_adr.size()), 64'd2);

        // Write strobe shape over the whole run
        check("cs_single_cycle", 64'(cs_long), 64'd0);
        check("we_tracks_cs", 64'(we_no_cs), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pram_loader.md
Name: pram_loader

Overview:
Initiator-side writer for the 4096x16 program RAM: it fills the RAM from a byte stream, such as a UART receiver or debug port, before the core is released.
- Frame format: 16-bit word count N, then 2N data bytes, then one checksum byte.
- Drives the RAM's cs, we (active-high), address and write-data pins directly.
- Reports done or an error code.

Parameters:
ADDR_W, 12, RAM address width; maximum frame length is 2**ADDR_W words.
DATA_W, 16, RAM word width; fixed at 2 bytes per word.
TIMEOUT_CYC, 65535, consecutive cycles without an accepted byte before aborting; 0 disables the timeout.

Ports:
clk  in  1  system clock, same clock as the RAM
rst_n  in  1  reset; one clock; reset is asynchronous and active-low
start  in  1  single-cycle pulse that begins a frame; ignored while busy
rx_data  in  8  incoming byte
rx_valid  in  1  byte available
rx_ready  out  1  loader accepts a byte; a transfer occurs when rx_valid and rx_ready are both high
pram_cs  out  1  RAM chip select
pram_we  out  1  RAM write enable, active-high
pram_adr  out  ADDR_W  RAM address
pram_data  out  DATA_W  RAM write data
busy  out  1  frame in progress
done  out  1  last frame loaded and checksum ok; held until next start
err  out  2  00 none, 01 bad length, 10 checksum mismatch, 11 timeout; held until next start

Behaviour:
- Reset: all outputs 0 and state IDLE, applied asynchronously. A reset mid-frame aborts the frame. The RAM retains partial contents.
- All outputs are registered.
- States: IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, WRITE, CHK, DONE, ERR.
- IDLE/DONE/ERR + start -> LEN_HI.
  - On that edge: done=0, err=00, word index=0, sum=0, busy=1.
- rx_ready=1 only in LEN_HI, LEN_LO, DATA_HI, DATA_LO and CHK. Each state advances on an accepted byte.
- Bytes are big-endian: high byte first for both the length and each data word.
- LEN_LO exit:
  - N=0 or N>2**ADDR_W -> ERR with err=01.
  - Otherwise -> DATA_HI.
- DATA_LO accept -> WRITE.
  - pram_data={hi,lo} and pram_adr=index are registered on that edge.
- WRITE lasts exactly one cycle with pram_cs=1 and pram_we=1.
  - The RAM captures on the next rising edge.
  - index==N-1 -> CHK; otherwise index+1 and -> DATA_HI.
- pram_cs and pram_we are 0 in every state except WRITE. pram_adr and pram_data hold their last values otherwise.
- Throughput: at most one word per 3 cycles.
- Checksum:
  - sum is the 8-bit modulo-256 sum of every accepted byte, including the length bytes and the checksum byte.
  - At CHK accept, sum==0 -> DONE (done=1); otherwise -> ERR with err=10.
- Timeout:
  - Active in LEN_LO, DATA_HI, DATA_LO and CHK. LEN_HI waits indefinitely.
  - The counter clears on each accepted byte and on state entry.
  - After TIMEOUT_CYC consecutive cycles without an accepted byte -> ERR with err=11.
- busy=0 in IDLE, DONE and ERR.
- start arriving in the same cycle as an accepted byte while busy is ignored.
- No write occurs after an error. Writes already completed are not undone.

Decomposition:
- Package pram_loader_pkg:
  - state enum
  - error codes ERR_NONE, ERR_LEN, ERR_CHK, ERR_TMO
  - BYTES_PER_WORD=2
- One sub-module, pram_loader_timer: idle-cycle counter with clear and enable inputs, TIMEOUT_CYC parameter and an expired output. The timer is disabled when TIMEOUT_CYC=0.

Test Plan:
- Nominal load. Stream 00 02 12 34 AB CD 40 with rx_valid high.
  - Expect a write to adr 000 of 1234, then adr 001 of ABCD, each as a 1-cycle cs/we pulse.
  - Then done=1, err=00, busy=0.
- Bad checksum. Same frame with 41 as the last byte.
  - Both writes occur; done=0, err=10.
- Bad length. 00 00 -> err=01 with no pram_cs pulse. Repeat with 10 01 -> err=01.
- Full frame. N=1000 (4096 words) with incrementing data and a correct checksum.
  - Last write goes to adr FFF; no write beyond it; done=1.
  - Add random rx_valid gaps: no byte is lost or duplicated.
- Timeout. TIMEOUT_CYC=16; send 00 03 12, then hold rx_valid=0.
  - err=11 after 16 idle cycles; rx_ready=0 afterwards.
  - A new start loads a clean frame successfully.
- Reset mid-frame. Assert rst_n=0 while in DATA_LO.
  - All outputs go to 0 immediately, with no pram_we pulse.
  - After release the loader is in IDLE; a following start and a valid frame give done=1.
